// File: rtl/alu_issue_seq.sv
// ============================================================================
// Module   : alu_issue_seq
// Brief    : Issue/writeback sequencer for the 32-bit combinational ALU.
//            Decodes one instruction, drives the ALU, and returns the result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [2:0]       alu_ctl,
  output logic [4:0]       alu_shamt,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_dest,
  output logic             out_wen,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        in1_q, in1_d, in2_q, in2_d;
  logic [2:0]         ctl_q, ctl_d;
  logic [4:0]         shamt_q, shamt_d, dest_q, dest_d;
  logic               is_add_q, is_add_d, is_sub_q, is_sub_d;
  logic               illegal_q, illegal_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         odest_q, odest_d;
  logic               wen_q, wen_d, ovf_q, ovf_d, oill_q, oill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [5:0]         w_opcode, w_funct;
  logic               w_ovf;

  assign w_opcode = in_instr[31:26];
  assign w_funct  = in_instr[5:0];

  // Signed overflow judged on the operands actually presented to the ALU
  assign w_ovf = (is_add_q && (in1_q[31] == in2_q[31]) && (alu_result[31] != in1_q[31])) ||
                 (is_sub_q && (in1_q[31] != in2_q[31]) && (alu_result[31] != in1_q[31]));

  always_comb begin
    state_d   = state_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    ctl_d     = ctl_q;
    shamt_d   = shamt_q;
    dest_d    = dest_q;
    is_add_d  = is_add_q;
    is_sub_d  = is_sub_q;
    illegal_d = illegal_q;
    res_d     = res_q;
    odest_d   = odest_q;
    wen_d     = wen_q;
    ovf_d     = ovf_q;
    oill_d    = oill_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = EXEC;
          in1_d     = in_rs_val;
          in2_d     = in_rt_val;
          ctl_d     = 3'b000;
          shamt_d   = 5'd0;
          dest_d    = in_instr[15:11];
          is_add_d  = 1'b0;
          is_sub_d  = 1'b0;
          illegal_d = 1'b0;
          if (w_opcode == 6'd0) begin
            case (w_funct)
              6'd0:  begin ctl_d = 3'b100; in1_d = in_rt_val; shamt_d = in_instr[10:6]; end
              6'd2:  begin ctl_d = 3'b101; in1_d = in_rt_val; shamt_d = in_instr[10:6]; end
              6'd3:  begin ctl_d = 3'b110; in1_d = in_rt_val; shamt_d = in_instr[10:6]; end
              6'd32: begin ctl_d = 3'b000; is_add_d = 1'b1; end
              6'd34: begin ctl_d = 3'b001; is_sub_d = 1'b1; end
              6'd36: ctl_d = 3'b010;
              6'd37: ctl_d = 3'b011;
              6'd42: ctl_d = 3'b111;
              default: illegal_d = 1'b1;
            endcase
          end else if (w_opcode == 6'd8) begin
            in2_d    = {{16{in_instr[15]}}, in_instr[15:0]};
            dest_d   = in_instr[20:16];
            is_add_d = 1'b1;
          end else if (w_opcode == 6'd12) begin
            ctl_d  = 3'b010;
            in2_d  = {16'd0, in_instr[15:0]};
            dest_d = in_instr[20:16];
          end else begin
            illegal_d = 1'b1;
          end
          if (illegal_d) begin
            in1_d    = 32'd0;
            in2_d    = 32'd0;
            ctl_d    = 3'b000;
            shamt_d  = 5'd0;
            dest_d   = 5'd0;
            is_add_d = 1'b0;
            is_sub_d = 1'b0;
          end
        end
      end
      EXEC: begin
        state_d = DONE;
        res_d   = illegal_q ? 32'd0 : alu_result;
        odest_d = dest_q;
        ovf_d   = w_ovf;
        oill_d  = illegal_q;
        wen_d   = !illegal_q && !w_ovf && (dest_q != 5'd0);
        if (!illegal_q && !w_ovf && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in1_q     <= 32'd0;
      in2_q     <= 32'd0;
      ctl_q     <= 3'b000;
      shamt_q   <= 5'd0;
      dest_q    <= 5'd0;
      is_add_q  <= 1'b0;
      is_sub_q  <= 1'b0;
      illegal_q <= 1'b0;
      res_q     <= 32'd0;
      odest_q   <= 5'd0;
      wen_q     <= 1'b0;
      ovf_q     <= 1'b0;
      oill_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      ctl_q     <= ctl_d;
      shamt_q   <= shamt_d;
      dest_q    <= dest_d;
      is_add_q  <= is_add_d;
      is_sub_q  <= is_sub_d;
      illegal_q <= illegal_d;
      res_q     <= res_d;
      odest_q   <= odest_d;
      wen_q     <= wen_d;
      ovf_q     <= ovf_d;
      oill_q    <= oill_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_ctl      = ctl_q;
  assign alu_shamt    = shamt_q;
  assign out_result   = res_q;
  assign out_dest     = odest_q;
  assign out_wen      = wen_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = oill_q;
  assign op_count     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
// ============================================================================
// Module   : tb_alu_issue_seq
// Brief    : Directed plus randomized checks of alu_issue_seq against an
//            instruction-level reference model and a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0, in_rs_val = 32'd0, in_rt_val = 32'd0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [2:0]  alu_ctl;
  logic [4:0]  alu_shamt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wen, out_overflow, out_illegal;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;

  alu_issue_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_wen(out_wen),
    .out_overflow(out_overflow), .out_illegal(out_illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU on the far side of the interface
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctl)
      3'b000: alu_result = alu_in1 + alu_in2;
      3'b001: alu_result = alu_in1 - alu_in2;
      3'b010: alu_result = alu_in1 & alu_in2;
      3'b011: alu_result = alu_in1 | alu_in2;
      3'b100: alu_result = alu_in1 << alu_shamt;
      3'b101: alu_result = alu_in1 >> alu_shamt;
      3'b110: alu_result = $signed(alu_in1) >>> alu_shamt;
      3'b111: alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level semantics: what each instruction means, not how it is built
  function automatic void model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                output logic legal, output logic is_shift, output logic [2:0] ctl,
                                output logic [31:0] in1, output logic [31:0] in2,
                                output logic [4:0] sh, output logic [4:0] dest,
                                output logic [31:0] res, output logic ovf);
    logic [31:0] imm_s, imm_z;
    longint s;
    imm_s = {{16{ins[15]}}, ins[15:0]};
    imm_z = {16'd0, ins[15:0]};
    legal = 1'b1; is_shift = 1'b0; ctl = 3'd0; in1 = 32'd0; in2 = 32'd0;
    sh = 5'd0; dest = 5'd0; res = 32'd0; ovf = 1'b0; s = 0;
    if (ins[31:26] == 6'd0) begin
      dest = ins[15:11]; in1 = rs; in2 = rt;
      case (ins[5:0])
        6'd0:  begin ctl = 3'd4; is_shift = 1'b1; in1 = rt; sh = ins[10:6]; res = rt << ins[10:6]; end
        6'd2:  begin ctl = 3'd5; is_shift = 1'b1; in1 = rt; sh = ins[10:6]; res = rt >> ins[10:6]; end
        6'd3:  begin ctl = 3'd6; is_shift = 1'b1; in1 = rt; sh = ins[10:6]; res = $signed(rt) >>> ins[10:6]; end
        6'd32: begin ctl = 3'd0; s = longint'($signed(rs)) + longint'($signed(rt)); res = rs + rt;
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        6'd34: begin ctl = 3'd1; s = longint'($signed(rs)) - longint'($signed(rt)); res = rs - rt;
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        6'd36: begin ctl = 3'd2; res = rs & rt; end
        6'd37: begin ctl = 3'd3; res = rs | rt; end
        6'd42: begin ctl = 3'd7; res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        default: legal = 1'b0;
      endcase
    end else if (ins[31:26] == 6'd8) begin
      ctl = 3'd0; in1 = rs; in2 = imm_s; dest = ins[20:16];
      s = longint'($signed(rs)) + longint'($signed(imm_s)); res = rs + imm_s;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (ins[31:26] == 6'd12) begin
      ctl = 3'd2; in1 = rs; in2 = imm_z; dest = ins[20:16]; res = rs & imm_z;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      ctl = 3'd0; in1 = 32'd0; in2 = 32'd0; res = 32'd0; ovf = 1'b0;
    end
  endfunction

  // One full transaction: accept, EXEC checks, DONE checks, stall, release
  task automatic do_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input int stall);
    logic legal, is_shift, ovf, wen;
    logic [2:0] ctl;
    logic [31:0] in1, in2, res;
    logic [4:0] sh, dest;
    model(ins, rs, rt, legal, is_shift, ctl, in1, in2, sh, dest, res, ovf);
    wen = legal && !ovf && (dest != 5'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_instr = ins; in_rs_val = rs; in_rt_val = rt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    chk("exec_out_valid", 32'(out_valid), 32'd0);
    chk("exec_alu_ctl", 32'(alu_ctl), 32'(ctl));
    chk("exec_alu_in1", alu_in1, in1);
    if (!is_shift) chk("exec_alu_in2", alu_in2, in2);
    if (legal) chk("exec_alu_shamt", 32'(alu_shamt), 32'(sh));
    @(posedge clk); #1;
    if (legal && !ovf && cnt_exp < 65535) cnt_exp++;
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_result", out_result, res);
    chk("done_illegal", 32'(out_illegal), 32'(!legal));
    chk("done_overflow", 32'(out_overflow), 32'(ovf));
    chk("done_wen", 32'(out_wen), 32'(wen));
    if (legal) chk("done_dest", 32'(out_dest), 32'(dest));
    chk("done_op_count", 32'(op_count), 32'(cnt_exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_result", out_result, res);
      chk("stall_wen", 32'(out_wen), 32'(wen));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ins, rs, rt;
    int k;
    // Reset held two cycles with a pending request
    rst_n = 1'b0; in_valid = 1'b1; in_instr = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {27'd0, out_dest}, 32'd0);
    chk("rst_wen_ovf_ill", {29'd0, out_wen, out_overflow, out_illegal}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_alu_ctl_sh", {24'd0, alu_ctl, alu_shamt}, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32}, 32'd5, 32'd7, 0);              // ADD
    do_op({6'd8, 5'd1, 5'd2, 16'h0001}, 32'h7FFFFFFF, 32'd0, 0);                 // ADDI overflow
    do_op({6'd0, 5'd0, 5'd2, 5'd4, 5'd4, 6'd3}, 32'd0, 32'h80000000, 0);         // SRA
    do_op({6'h23, 5'd1, 5'd2, 16'h0010}, 32'h11111111, 32'h22222222, 0);         // illegal opcode
    do_op({6'd12, 5'd1, 5'd5, 16'hFFFF}, 32'h1234ABCD, 32'd0, 0);                // ANDI
    do_op({6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd32}, 32'd1, 32'd2, 0);               // dest r0
    do_op({6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd34}, 32'h80000000, 32'd1, 0);        // SUB overflow
    do_op({6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd33}, 32'd3, 32'd4, 5);               // illegal funct, back-pressure

    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 11));
      ins = $urandom;
      case (k)
        0: ins[31:26] = 6'd0;
        1, 2: begin ins[31:26] = 6'd0; ins[5:0] = 6'd32; end
        3: begin ins[31:26] = 6'd0; ins[5:0] = 6'd34; end
        4: begin ins[31:26] = 6'd0; ins[5:0] = (n % 2 == 0) ? 6'd36 : 6'd37; end
        5: begin ins[31:26] = 6'd0; ins[5:0] = 6'd42; end
        6: begin ins[31:26] = 6'd0; ins[5:0] = 6'd0; end
        7: begin ins[31:26] = 6'd0; ins[5:0] = (n % 2 == 0) ? 6'd2 : 6'd3; end
        8, 9: ins[31:26] = 6'd8;
        10: ins[31:26] = 6'd12;
        default: ;
      endcase
      rs = $urandom;
      rt = $urandom;
      if (n % 5 == 0) rs = 32'h7FFFFFF0 + 32'($urandom_range(0, 15));
      if (n % 7 == 0) rt = 32'h80000000;
      do_op(ins, rs, rt, int'($urandom_range(0, 2)));
    end

    // Reset while the result waits in DONE discards it
    chk("pre_idle", 32'(in_ready), 32'd1);
    in_instr = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd32}; in_rs_val = 32'd10; in_rt_val = 32'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_done_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_exp = 0;
    chk("rst_done_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done_result", out_result, 32'd0);
    chk("rst_done_op_count", 32'(op_count), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    do_op({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd37}, 32'hF0F0F0F0, 32'h0F0F0F0F, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
